// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that writes a framed UART byte stream into
// the instruction RAM. It holds the CPU in reset until a complete image has
// been written and its checksum matches.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for the sync byte; every other byte is ignored
// CNT_HI | next byte is the high byte of the word count
// CNT_LO | next byte is the low byte of the word count
// DATA   | assembling big-endian words and writing each completed word
// CSUM   | next byte must equal the XOR of all data bytes
// DONE   | image verified; the CPU is released
// ERR    | last frame failed; the CPU is held until the next sync byte
module imem_loader #(
   parameter int          DEPTH_WORDS    = 256,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int          TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        error
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA, S_CSUM, S_DONE, S_ERR
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [15:0]   word_idx_q, word_idx_d;
   logic [1:0]    byte_idx_q, byte_idx_d;
   logic [7:0]    csum_q, csum_d;
   logic [23:0]   asm_q, asm_d;
   logic [TW-1:0] idle_cnt_q, idle_cnt_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          hold_q, hold_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   logic          timed;
   logic [15:0]   n_new;
   logic [15:0]   word_idx_inc;

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      word_idx_d   = word_idx_q;
      byte_idx_d   = byte_idx_q;
      csum_d       = csum_q;
      asm_d        = asm_q;
      idle_cnt_d   = idle_cnt_q;
      we_d         = 1'b0;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      n_new        = {cnt_q[15:8], rx_data};
      word_idx_inc = word_idx_q + 16'd1;
      timed        = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                     (state_q == S_DATA)   || (state_q == S_CSUM);

      if (rx_valid) begin
         case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
               if (rx_data == SYNC_BYTE) state_d = S_CNT_HI;
            end
            S_CNT_HI: begin
               cnt_d   = {rx_data, 8'h00};
               state_d = S_CNT_LO;
            end
            S_CNT_LO: begin
               cnt_d      = n_new;
               word_idx_d = '0;
               byte_idx_d = '0;
               csum_d     = '0;
               if (n_new > 16'(DEPTH_WORDS)) state_d = S_ERR;
               else if (n_new == 16'd0)      state_d = S_CSUM;
               else                          state_d = S_DATA;
            end
            S_DATA: begin
               csum_d     = csum_q ^ rx_data;
               asm_d      = {asm_q[15:0], rx_data};
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  we_d       = 1'b1;
                  addr_d     = {14'd0, word_idx_q, 2'b00};
                  wdata_d    = {asm_q, rx_data};
                  word_idx_d = word_idx_inc;
                  if (word_idx_inc == cnt_q) state_d = S_CSUM;
               end
            end
            S_CSUM: begin
               state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
         endcase
      end else if (timed) begin
         // The edge that would bring the idle count to TIMEOUT_CYCLES aborts.
         if (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1)) state_d = S_ERR;
         else idle_cnt_d = idle_cnt_q + 1'b1;
      end

      if (rx_valid || (state_d != state_q) || !timed) idle_cnt_d = '0;

      hold_d = (state_d != S_DONE);
      done_d = (state_d == S_DONE);
      err_d  = (state_d == S_ERR);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         word_idx_q <= '0;
         byte_idx_q <= '0;
         csum_q     <= '0;
         asm_q      <= '0;
         idle_cnt_q <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         hold_q     <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         word_idx_q <= word_idx_d;
         byte_idx_q <= byte_idx_d;
         csum_q     <= csum_d;
         asm_q      <= asm_d;
         idle_cnt_q <= idle_cnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         hold_q     <= hold_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_hold   = hold_q;
   assign done       = done_q;
   assign error      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: table of frames plus hand-written sequences
// for timeout, reset and a full-depth back-to-back image.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        error;

   int total = 0;
   int bad   = 0;
   int wr_seen = 0;
   logic [63:0] exp_q[$];

   imem_loader #(
      .DEPTH_WORDS(256),
      .SYNC_BYTE(8'hA5),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .imem_we(imem_we),
      .imem_addr(imem_addr),
      .imem_wdata(imem_wdata),
      .cpu_hold(cpu_hold),
      .done(done),
      .error(error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] b;
      int           n;
      int           nwr;
      logic [31:0]  wa0, wd0, wa1, wd1;
      logic         e_done, e_err, e_hold;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
   endtask

   task automatic end_frame();
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic chk_status(input string nm, input logic e_done, input logic e_err,
                             input logic e_hold);
      chk({nm, "_done"}, 32'(done), 32'(e_done));
      chk({nm, "_error"}, 32'(error), 32'(e_err));
      chk({nm, "_cpu_hold"}, 32'(cpu_hold), 32'(e_hold));
      chk({nm, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
   endtask

   // Scoreboard: every write pulse must match the oldest expected write.
   always @(negedge clk) begin
      if (imem_we) begin
         wr_seen++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write addr=%h data=%h", imem_addr, imem_wdata);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            if ({imem_addr, imem_wdata} !== e) begin
               bad++;
               $display("FAIL write actual=%h_%h expected=%h_%h",
                        imem_addr, imem_wdata, e[63:32], e[31:0]);
            end
         end
         total++;
         if (cpu_hold !== 1'b1) begin
            bad++;
            $display("FAIL hold_during_write actual=%b expected=1", cpu_hold);
         end
      end
   end

   initial begin
      logic [7:0]  cs;
      logic [31:0] w;
      int          wr_base;

      vecs[0] = '{128'h00FFA50002241D010024040000180000, 14, 2,
                  32'h0, 32'h241D0100, 32'h4, 32'h24040000, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{128'hA50002241D0100240400001900000000, 12, 2,
                  32'h0, 32'h241D0100, 32'h4, 32'h24040000, 1'b0, 1'b1, 1'b1};
      vecs[2] = '{128'hA50002241D0100240400001800000000, 12, 2,
                  32'h0, 32'h241D0100, 32'h4, 32'h24040000, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{128'hA5010100000000000000000000000000, 3, 0,
                  32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1};
      vecs[4] = '{128'hA5000000000000000000000000000000, 4, 0,
                  32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{128'hA5000000000000000000000000000000, 1, 0,
                  32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{128'h0001DEADBEEF22000000000000000000, 7, 1,
                  32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0};
      vecs[7] = '{128'h33000000000000000000000000000000, 1, 0,
                  32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0};

      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_we", 32'(imem_we), 32'd0);
      chk("rst_addr", imem_addr, 32'd0);
      chk("rst_wdata", imem_wdata, 32'd0);
      chk_status("rst", 1'b0, 1'b0, 1'b1);
      reset = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 8; v++) begin
         if (vecs[v].nwr > 0) exp_q.push_back({vecs[v].wa0, vecs[v].wd0});
         if (vecs[v].nwr > 1) exp_q.push_back({vecs[v].wa1, vecs[v].wd1});
         for (int i = 0; i < vecs[v].n; i++)
            send_byte(vecs[v].b[127-8*i -: 8]);
         end_frame();
         chk_status($sformatf("vec%0d", v), vecs[v].e_done, vecs[v].e_err, vecs[v].e_hold);
      end

      // Timeout: 16 idle edges after the last byte abort the frame.
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
      send_byte(8'h24); send_byte(8'h1D);
      end_frame();
      repeat (15) @(negedge clk);
      chk("timeout_15_error", 32'(error), 32'd0);
      @(negedge clk);
      chk_status("timeout_16", 1'b0, 1'b1, 1'b1);

      // A byte arriving on the 16th idle edge keeps the frame alive.
      exp_q.push_back({32'h0, 32'h241D0100});
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
      send_byte(8'h24); send_byte(8'h1D);
      end_frame();
      repeat (14) @(negedge clk);
      chk("rescue_error_pre", 32'(error), 32'd0);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h38);
      end_frame();
      chk_status("rescue", 1'b1, 1'b0, 1'b0);

      // Reset in the middle of DATA; the first word is already written.
      exp_q.push_back({32'h0, 32'h241D0100});
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h24); send_byte(8'h1D); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h24);
      end_frame();
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_we", 32'(imem_we), 32'd0);
      chk("midrst_addr", imem_addr, 32'd0);
      chk("midrst_wdata", imem_wdata, 32'd0);
      chk_status("midrst", 1'b0, 1'b0, 1'b1);
      reset = 1'b0;
      exp_q.push_back({32'h0, 32'hDEADBEEF});
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
      send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
      send_byte(8'h22);
      end_frame();
      chk_status("after_rst", 1'b1, 1'b0, 1'b0);

      // Full-depth image, rx_valid high every cycle.
      wr_base = wr_seen;
      cs = 8'h00;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      for (int i = 0; i < 256; i++) begin
         w = $urandom;
         exp_q.push_back({32'(i) << 2, w});
         cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
         send_byte(w[31:24]); send_byte(w[23:16]);
         send_byte(w[15:8]);  send_byte(w[7:0]);
      end
      send_byte(cs);
      end_frame();
      chk_status("full", 1'b1, 1'b0, 1'b0);
      chk("full_write_count", 32'(wr_seen - wr_base), 32'd256);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
